uart_tx_sched: RTL and testbench

- Shares one UART transmitter (uart_t instance, handshake newd/tx_data/donetx) among NUM_REQ byte-producing requesters.
- Round-robin arbitration; one byte accepted per frame.
- Sequences the transmitter's slow-clock handshake from the fast clk domain and reports per-requester completion.
- Includes a watchdog that recovers from a stalled transmitter.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rr_pick.sv | 36 +++
 rtl/uart_tx_sched.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
//   sched_state_t : scheduler FSM states
//   UART_DATA_W   : width of one UART payload byte
//   id_width()    : requester-index width that never collapses to zero bits
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } sched_state_t;

    // $clog2 returns 0 for a single requester; an index always needs one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector.
// Ports:
//   req   (in)  : pending-request vector, one bit per requester
//   ptr   (in)  : index of the most recent winner
//   found (out) : at least one request bit is set
//   idx   (out) : first set bit searching upward from ptr+1, wrapping
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    // Walk the requesters starting just after the last winner so the previous
    // owner is considered last; the first hit is kept and later hits ignored.
    always_comb begin
        int         cand;
        logic [IDX_W-1:0] cand_idx;
        found    = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(ptr) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among NUM_REQ byte producers.
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   req_valid    : per-requester byte pending
//   req_data     : per-requester byte, requester i in [8i+7:8i]
//   req_ready    : one-cycle pulse, byte of requester i accepted
//   req_done     : one-cycle pulse, frame of requester i completed
//   grant_id     : requester currently owning the transmitter
//   busy         : scheduler is not idle
//   timeout_err  : one-cycle pulse when the watchdog aborts a frame
//   newd, tx_data: request/byte towards the transmitter
//   donetx       : transmitter status, low while a frame is in flight
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         req_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err,
    output logic                       newd,
    output logic [UART_DATA_W-1:0]     tx_data,
    input  logic                       donetx
);

    localparam int IDX_W = id_width(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    sched_state_t           state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic                   newd_q, newd_d;
    logic [NUM_REQ-1:0]     ready_q, ready_d;
    logic [NUM_REQ-1:0]     done_q, done_d;
    logic                   tout_q, tout_d;
    logic [WD_W-1:0]        wdog_q, wdog_d;

    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // All scheduler state lives here; reset returns to idle with the pointer
    // on the last requester so requester 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            grant_q <= '0;
            data_q  <= '0;
            newd_q  <= 1'b0;
            ready_q <= '0;
            done_q  <= '0;
            tout_q  <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            newd_q  <= newd_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            tout_q  <= tout_d;
            wdog_q  <= wdog_d;
        end
    end

    // Next-state logic. Pulses default low every cycle. In both wait states the
    // transmitter's answer is checked before the watchdog, so a frame finishing
    // on the very last allowed cycle completes normally instead of aborting.
    // Equality compares keep an unknown donetx from counting as an answer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
        newd_d  = newd_q;
        ready_d = '0;
        done_d  = '0;
        tout_d  = 1'b0;
        wdog_d  = wdog_q;

        case (state_q)
            IDLE: begin
                newd_d = 1'b0;
                if (pick_found) begin
                    ready_d = NUM_REQ'(1) << pick_idx;
                    grant_d = pick_idx;
                    data_d  = req_data[UART_DATA_W*int'(pick_idx) +: UART_DATA_W];
                    ptr_d   = pick_idx;
                    newd_d  = 1'b1;
                    wdog_d  = '0;
                    state_d = LAUNCH;
                end
            end

            LAUNCH: begin
                newd_d = 1'b1;
                if (donetx == 1'b0) begin
                    newd_d  = 1'b0;
                    wdog_d  = '0;
                    state_d = WAIT_DONE;
                end else if (wdog_q == WD_LAST) begin
                    tout_d  = 1'b1;
                    newd_d  = 1'b0;
                    wdog_d  = '0;
                    state_d = IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end

            WAIT_DONE: begin
                newd_d = 1'b0;
                if (donetx == 1'b1) begin
                    done_d  = NUM_REQ'(1) << grant_q;
                    state_d = IDLE;
                end else if (wdog_q == WD_LAST) begin
                    tout_d  = 1'b1;
                    wdog_d  = '0;
                    state_d = IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end

            default: begin
                newd_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign req_ready   = ready_q;
    assign req_done    = done_q;
    assign grant_id    = grant_q;
    assign timeout_err = tout_q;
    assign newd        = newd_q;
    assign tx_data     = data_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: behavioural UART transmitter and
// line receiver, round-robin reference model, directed and random stimulus.
module tb_uart_tx_sched;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 64;
    localparam int BIT_CYC = 4;
    localparam int ACK_DLY = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   req_done;
    logic [1:0]           grant_id;
    logic                 busy;
    logic                 timeout_err;
    logic                 newd;
    logic [7:0]           tx_data;
    logic                 donetx;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .req_done    (req_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err),
        .newd        (newd),
        .tx_data     (tx_data),
        .donetx      (donetx)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Counts one comparison and reports it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural transmitter: idles with donetx high, answers newd after a short
    // delay by dropping donetx, shifts start/8 data LSB-first/stop, then raises donetx.
    // With tx_stuck set it ignores newd entirely.
    bit         tx_stuck = 1'b0;
    logic       serial;
    int         tx_phase, tx_cnt, tx_bit, tx_sub;
    logic [7:0] tx_byte;

    initial begin
        donetx = 1'b1; serial = 1'b1; tx_phase = 0;
        tx_cnt = 0; tx_bit = 0; tx_sub = 0; tx_byte = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                donetx = 1'b1; serial = 1'b1; tx_phase = 0;
            end else begin
                case (tx_phase)
                    0: if (newd === 1'b1 && !tx_stuck) begin
                        tx_phase = 1; tx_cnt = ACK_DLY;
                    end
                    1: begin
                        tx_cnt--;
                        if (tx_cnt == 0) begin
                            tx_byte = tx_data; donetx = 1'b0; serial = 1'b0;
                            tx_bit = 0; tx_sub = 0; tx_phase = 2;
                        end
                    end
                    default: begin
                        tx_sub++;
                        if (tx_sub == BIT_CYC) begin
                            tx_sub = 0; tx_bit++;
                            if (tx_bit == 10) begin
                                serial = 1'b1; donetx = 1'b1; tx_phase = 0;
                            end else begin
                                serial = (tx_bit <= 8) ? tx_byte[tx_bit-1] : 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Monitor state: line receiver, round-robin reference and scoreboard.
    int               model_ptr, cyc_since, acc_id, exp_id, timeouts, rx_cnt, rx_k;
    bit               in_flight, rx_active;
    logic [7:0]       acc_byte, rx_byte;
    logic [7:0]       rx_q[$];
    int               grants[$];
    int               done_cnt[NUM_REQ];
    logic             last_rst, last_busy;
    logic [NUM_REQ-1:0]   last_valid;
    logic [8*NUM_REQ-1:0] last_data;

    // Sampled on the falling edge. Decodes the serial line mid-bit, then checks
    // the cycle's DUT outputs against what the inputs seen at the preceding
    // rising edge require.
    initial begin
        model_ptr = NUM_REQ-1; cyc_since = 0; acc_id = 0; exp_id = -1; timeouts = 0;
        in_flight = 1'b0; rx_active = 1'b0; rx_cnt = 0; rx_k = 0;
        acc_byte = 8'h00; rx_byte = 8'h00;
        last_rst = 1'b0; last_busy = 1'b1; last_valid = '0; last_data = '0;
        for (int i = 0; i < NUM_REQ; i++) done_cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rx_active = 1'b0;
            end else if (!rx_active) begin
                if (serial === 1'b0) begin rx_active = 1'b1; rx_cnt = 0; end
            end else begin
                rx_cnt++;
                if (rx_cnt % BIT_CYC == BIT_CYC/2) begin
                    rx_k = rx_cnt / BIT_CYC;
                    if (rx_k >= 1 && rx_k <= 8) rx_byte[rx_k-1] = serial;
                    else if (rx_k == 9) begin
                        if (serial === 1'b1) rx_q.push_back(rx_byte);
                        rx_active = 1'b0;
                    end
                end
            end

            if (last_rst) begin
                checkOutput("rst_busy", busy, 0);
                checkOutput("rst_newd", newd, 0);
                checkOutput("rst_ready", req_ready, 0);
                checkOutput("rst_done", req_done, 0);
                checkOutput("rst_timeout", timeout_err, 0);
                checkOutput("rst_grant_id", grant_id, 0);
                checkOutput("rst_tx_data", tx_data, 0);
                model_ptr = NUM_REQ-1; in_flight = 1'b0; rx_q.delete();
            end else begin
                if (in_flight) cyc_since++;
                if (last_busy === 1'b0) begin
                    exp_id = -1;
                    for (int k = 1; k <= NUM_REQ; k++) begin
                        int c;
                        c = (model_ptr + k) % NUM_REQ;
                        if (exp_id < 0 && last_valid[c]) exp_id = c;
                    end
                    if (exp_id >= 0 || req_ready != '0)
                        checkOutput("ready_vec", req_ready, (exp_id >= 0) ? (32'd1 << exp_id) : 32'd0);
                    if (exp_id >= 0 && req_ready != '0) begin
                        checkOutput("grant_id", grant_id, exp_id);
                        checkOutput("tx_data", tx_data, last_data[8*exp_id +: 8]);
                        checkOutput("newd_launch", newd, 1);
                        checkOutput("busy_launch", busy, 1);
                        model_ptr = exp_id; acc_id = exp_id;
                        acc_byte = last_data[8*exp_id +: 8];
                        in_flight = 1'b1; cyc_since = 0;
                        grants.push_back(exp_id);
                    end
                end else if (req_ready != '0) begin
                    checkOutput("ready_while_busy", req_ready, 0);
                end

                if (req_done != '0) begin
                    if (in_flight) begin
                        checkOutput("done_vec", req_done, 32'd1 << acc_id);
                        checkOutput("done_not_stuck", tx_stuck, 0);
                        checkOutput("busy_after_done", busy, 0);
                        checkOutput("rx_frame_count", rx_q.size(), 1);
                        if (rx_q.size() > 0) checkOutput("rx_byte", rx_q.pop_front(), acc_byte);
                        done_cnt[acc_id]++;
                        in_flight = 1'b0;
                    end else begin
                        checkOutput("done_unexpected", req_done, 0);
                    end
                end

                if (timeout_err === 1'b1) begin
                    checkOutput("timeout_expected", tx_stuck, 1);
                    checkOutput("timeout_latency", cyc_since, TIMEOUT);
                    checkOutput("timeout_newd", newd, 0);
                    checkOutput("busy_after_timeout", busy, 0);
                    timeouts++;
                    in_flight = 1'b0;
                end

                if (in_flight && cyc_since > TIMEOUT + 4) begin
                    checkOutput("inflight_hang", cyc_since, TIMEOUT);
                    in_flight = 1'b0;
                end
            end
            last_rst = rst; last_busy = busy; last_valid = req_valid; last_data = req_data;
        end
    end

    // Stimulus side: one clock step; accepted bytes are withdrawn, or refilled
    // with a fresh byte while a reload budget remains.
    bit reload = 1'b0;
    int reload_left = 0;

    task automatic stepClock();
        @(posedge clk); #2;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] === 1'b1) begin
                if (reload && reload_left > 0) begin
                    req_data[8*i +: 8] = 8'($urandom);
                    reload_left--;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] mask, input logic [8*NUM_REQ-1:0] data);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mask[i]) begin
                req_valid[i] = 1'b1;
                req_data[8*i +: 8] = data[8*i +: 8];
            end
        end
    endtask

    task automatic doReset(input int n);
        rst = 1'b1;
        repeat (n) stepClock();
        rst = 1'b0;
    endtask

    task automatic waitQuiet(input int budget);
        int n;
        n = 0;
        while ((busy !== 1'b0 || req_valid != '0 || in_flight) && n < budget) begin
            stepClock();
            n++;
        end
        checkOutput("quiet_reached", {busy, in_flight, |req_valid}, 0);
    endtask

    int base_g, base_d0, base_d1, base_d2, base_d3, base_to, rand_g, rand_d;

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0;
        repeat (3) stepClock();
        rst = 1'b0;

        $display("[TB] single request");
        applyStimulus(4'b0001, 32'h0000_00A5);
        waitQuiet(200);
        checkOutput("t1_grants", grants.size(), 1);
        if (grants.size() > 0) checkOutput("t1_winner", grants[0], 0);
        checkOutput("t1_done0", done_cnt[0], 1);

        $display("[TB] simultaneous requests");
        doReset(2);
        base_g = grants.size(); base_d1 = done_cnt[1]; base_d3 = done_cnt[3];
        applyStimulus(4'b1010, 32'h3300_1100);
        waitQuiet(300);
        checkOutput("t2_grants", grants.size() - base_g, 2);
        if (grants.size() >= base_g + 2) begin
            checkOutput("t2_first", grants[base_g], 1);
            checkOutput("t2_second", grants[base_g+1], 3);
        end
        checkOutput("t2_done1", done_cnt[1] - base_d1, 1);
        checkOutput("t2_done3", done_cnt[3] - base_d3, 1);

        $display("[TB] continuous contention");
        doReset(2);
        base_g = grants.size();
        base_d0 = done_cnt[0]; base_d1 = done_cnt[1]; base_d2 = done_cnt[2]; base_d3 = done_cnt[3];
        reload = 1'b1; reload_left = 8;
        applyStimulus(4'b1111, $urandom);
        waitQuiet(1500);
        reload = 1'b0;
        checkOutput("t3_grants", grants.size() - base_g, 12);
        for (int j = 0; j < 12; j++)
            if (base_g + j < grants.size()) checkOutput("t3_order", grants[base_g+j], j % 4);
        checkOutput("t3_done0", done_cnt[0] - base_d0, 3);
        checkOutput("t3_done1", done_cnt[1] - base_d1, 3);
        checkOutput("t3_done2", done_cnt[2] - base_d2, 3);
        checkOutput("t3_done3", done_cnt[3] - base_d3, 3);

        $display("[TB] stuck transmitter");
        tx_stuck = 1'b1;
        base_g = grants.size(); base_to = timeouts; base_d1 = done_cnt[1];
        applyStimulus(4'b0010, 32'h0000_C300);
        waitQuiet(200);
        checkOutput("t4_timeouts", timeouts - base_to, 1);
        checkOutput("t4_no_done", done_cnt[1] - base_d1, 0);
        tx_stuck = 1'b0;
        applyStimulus(4'b0110, 32'h0096_6900);
        waitQuiet(300);
        checkOutput("t4_grants", grants.size() - base_g, 3);
        if (grants.size() >= base_g + 3) begin
            checkOutput("t4_aborted", grants[base_g], 1);
            checkOutput("t4_next", grants[base_g+1], 2);
        end

        $display("[TB] reset mid-frame");
        base_d0 = done_cnt[0]; base_d1 = done_cnt[1];
        applyStimulus(4'b0010, 32'h0000_7700);
        repeat (20) stepClock();
        checkOutput("t5_busy_before", busy, 1);
        doReset(1);
        stepClock();
        applyStimulus(4'b0001, 32'h0000_005A);
        base_g = grants.size();
        waitQuiet(200);
        checkOutput("t5_no_done1", done_cnt[1] - base_d1, 0);
        checkOutput("t5_done0", done_cnt[0] - base_d0, 1);
        if (grants.size() > base_g) checkOutput("t5_winner", grants[base_g], 0);

        $display("[TB] withdrawn request");
        base_g = grants.size(); base_d2 = done_cnt[2];
        applyStimulus(4'b0001, 32'h0000_00E1);
        repeat (10) stepClock();
        applyStimulus(4'b0100, 32'h00BB_0000);
        repeat (5) stepClock();
        req_valid[2] = 1'b0;
        waitQuiet(200);
        checkOutput("t6_grants", grants.size() - base_g, 1);
        checkOutput("t6_no_done2", done_cnt[2] - base_d2, 0);

        $display("[TB] random traffic");
        base_g = grants.size();
        base_d0 = done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3];
        for (int cyc = 0; cyc < 4000 && grants.size() - base_g < 30; cyc++) begin
            stepClock();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] && $urandom_range(7) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                end else if (req_valid[i] && $urandom_range(31) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        req_valid = '0;
        waitQuiet(200);
        rand_g = grants.size() - base_g;
        rand_d = done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3] - base_d0;
        checkOutput("rand_done_total", rand_d, rand_g);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
